// File: rtl/slt_chk_pkg.sv
// Shared types for the SLT result checker.
// State encoding, default widths and the S1 pipeline entry.
package slt_chk_pkg;

  localparam int DATA_W = 16;
  localparam int CNT_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  typedef struct packed {
    logic [CNT_DEF-1:0] idx;
    logic [DATA_W:0]    exp;
    logic [DATA_W:0]    got;
  } s1_t;

endpackage

// File: rtl/slt_golden_model.sv
// Combinational golden SLT: signed less-than plus
// the overflow of the underlying A-B subtraction.
module slt_golden_model #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] exp_out,
  output logic             exp_ovf
);

  logic [WIDTH-1:0] diff;
  logic             lt;

  assign diff = a - b;
  assign lt = $signed(a) < $signed(b);
  assign exp_out = {{(WIDTH-1){1'b0}}, lt};
  assign exp_ovf = (a[WIDTH-1] != b[WIDTH-1]) &&
                   (diff[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/slt_result_checker.sv
// Response checker for the SLT unit: golden compare
// in a 2-stage pipeline, pass/fail counts, first-fail capture.
module slt_result_checker
  import slt_chk_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int NUM_VECTORS = 6,
  parameter int CNT_W = CNT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_out,
  input  logic             in_ovf,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             ff_valid,
  output logic [CNT_W-1:0] ff_idx,
  output logic [WIDTH:0]   ff_exp,
  output logic [WIDTH:0]   ff_got
);

  state_t state, state_n;

  logic [CNT_W-1:0] acc_cnt;
  logic [WIDTH-1:0] g_out;
  logic             g_ovf;
  logic             accept;
  logic             clr;
  logic             last;

  s1_t              s1;
  logic             s1_v;
  logic             s2_v;
  logic             s2_mis;
  logic [CNT_W-1:0] s2_idx;
  logic [WIDTH:0]   s2_exp;
  logic [WIDTH:0]   s2_got;

  slt_golden_model #(
    .WIDTH(WIDTH)
  ) u_gold (
    .a      (in_a),
    .b      (in_b),
    .exp_out(g_out),
    .exp_ovf(g_ovf)
  );

  assign in_ready = (state == RUN);
  assign accept = in_valid && in_ready;
  assign clr = start && (state == IDLE || state == DONE);
  assign last = (acc_cnt == CNT_W'(NUM_VECTORS - 1));
  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign all_pass = done && (fail_cnt == '0);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = RUN;
      RUN:   if (accept && last) state_n = DRAIN;
      DRAIN: if (!s1_v && !s2_v) state_n = DONE;
      DONE:  if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_cnt <= '0;
    end else if (accept && acc_cnt != '1) begin
      acc_cnt <= acc_cnt + 1'b1;
    end
  end

  // S1: operands reduced to {ovf,out} pairs
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1 <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1.idx <= acc_cnt;
        s1.exp <= {g_ovf, g_out};
        s1.got <= {in_ovf, in_out};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_v <= 1'b0;
      s2_mis <= 1'b0;
      s2_idx <= '0;
      s2_exp <= '0;
      s2_got <= '0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_mis <= (s1.exp != s1.got);
        s2_idx <= s1.idx;
        s2_exp <= s1.exp;
        s2_got <= s1.got;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      ff_valid <= 1'b0;
      ff_idx <= '0;
      ff_exp <= '0;
      ff_got <= '0;
    end else if (s2_v) begin
      if (s2_mis) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (!ff_valid) begin
          ff_valid <= 1'b1;
          ff_idx <= s2_idx;
          ff_exp <= s2_exp;
          ff_got <= s2_got;
        end
      end else if (pass_cnt != '1) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_slt_result_checker.sv
// Randomized and directed bench for slt_result_checker,
// scored against an integer-arithmetic reference model.
module tb_slt_result_checker;

  logic        clk = 0;
  logic        rst = 1;
  logic        start = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [15:0] in_a = 0;
  logic [15:0] in_b = 0;
  logic [15:0] in_out = 0;
  logic        in_ovf = 0;
  logic        busy;
  logic        done;
  logic        all_pass;
  logic [7:0]  pass_cnt;
  logic [7:0]  fail_cnt;
  logic        ff_valid;
  logic [7:0]  ff_idx;
  logic [16:0] ff_exp;
  logic [16:0] ff_got;

  int n_checks = 0;
  int n_fail = 0;

  int          m_pass, m_fail, m_acc, m_ffi;
  bit          m_ffv;
  logic [16:0] m_ffe, m_ffg;

  slt_result_checker dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_out  (in_out),
    .in_ovf  (in_ovf),
    .busy    (busy),
    .done    (done),
    .all_pass(all_pass),
    .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt),
    .ff_valid(ff_valid),
    .ff_idx  (ff_idx),
    .ff_exp  (ff_exp),
    .ff_got  (ff_got)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {ovf, out} from plain integer arithmetic
  function automatic logic [16:0] ref_gold(logic [15:0] a,
                                           logic [15:0] b);
    int sa, sb, d;
    sa = $signed(a);
    sb = $signed(b);
    d = sa - sb;
    return {(d > 32767 || d < -32768), 15'b0, sa < sb};
  endfunction

  task automatic m_clear();
    m_pass = 0; m_fail = 0; m_acc = 0;
    m_ffv = 0; m_ffi = 0; m_ffe = 0; m_ffg = 0;
  endtask

  task automatic m_accept(logic [15:0] a, logic [15:0] b,
                          logic [16:0] got);
    logic [16:0] e;
    e = ref_gold(a, b);
    if (e != got) begin
      m_fail++;
      if (!m_ffv) begin
        m_ffv = 1; m_ffi = m_acc; m_ffe = e; m_ffg = got;
      end
    end else begin
      m_pass++;
    end
    m_acc++;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic feed(logic [15:0] a, logic [15:0] b,
                      logic [15:0] o, logic v);
    in_a = a; in_b = b; in_out = o; in_ovf = v;
    in_valid = 1;
    check("in_ready", in_ready, 1);
    tick();
    m_accept(a, b, {v, o});
  endtask

  task automatic wait_done();
    int i;
    in_valid = 0;
    for (i = 0; i < 20 && !done; i++) tick();
    if (!done) check("done_timeout", 0, 1);
  endtask

  task automatic check_stats(string tag);
    check({tag, "_pass"}, pass_cnt, m_pass);
    check({tag, "_fail"}, fail_cnt, m_fail);
    check({tag, "_allp"}, all_pass, m_fail == 0);
    check({tag, "_ffv"}, ff_valid, m_ffv);
    if (m_ffv) begin
      check({tag, "_ffi"}, ff_idx, m_ffi);
      check({tag, "_ffe"}, ff_exp, m_ffe);
      check({tag, "_ffg"}, ff_got, m_ffg);
    end
  endtask

  logic [15:0] va [6] = '{16'h0000, 16'h0004, 16'h0002,
                          16'hFFFC, 16'hFFFE, 16'h7FFF};
  logic [15:0] vb [6] = '{16'h0000, 16'h0002, 16'h0004,
                          16'hFFFE, 16'hFFFC, 16'h7FFF};
  logic [15:0] vo [6] = '{16'd0, 16'd0, 16'd1,
                          16'd1, 16'd0, 16'd0};

  initial begin
    m_clear();
    tick(); tick();
    rst = 0;

    // idle: in_valid ignored
    in_valid = 1; in_a = 16'h1234; in_b = 16'h8000;
    tick(); tick();
    check("idle_ready", in_ready, 0);
    check("idle_pass", pass_cnt, 0);
    check("idle_fail", fail_cnt, 0);
    check("idle_done", done, 0);
    check("idle_busy", busy, 0);
    check("idle_ffv", ff_valid, 0);
    in_valid = 0;

    // start with rst: reset wins
    rst = 1; start = 1;
    tick();
    rst = 0; start = 0;
    check("rst_start_busy", busy, 0);

    // directed all-pass, back to back
    pulse_start(); m_clear();
    for (int i = 0; i < 6; i++) feed(va[i], vb[i], vo[i], 0);
    wait_done();
    check_stats("dir");
    check("dir_done", done, 1);
    check("dir_pass6", pass_cnt, 6);

    // in_valid in DONE has no effect
    in_valid = 1; in_out = 16'hFFFF;
    tick(); tick(); tick();
    in_valid = 0;
    check("done_ignore", pass_cnt, 6);

    // vector 2 wrong
    pulse_start(); m_clear();
    for (int i = 0; i < 6; i++)
      feed(va[i], vb[i], (i == 2) ? 16'd0 : vo[i], 0);
    wait_done();
    check_stats("ff");
    check("ff_idx2", ff_idx, 2);
    check("ff_exp1", ff_exp, 17'h00001);
    check("ff_got0", ff_got, 17'h00000);

    // latency, start ignored in RUN, signed-overflow case
    pulse_start(); m_clear();
    feed(16'h8000, 16'h0001, 16'd1, 1);
    in_valid = 0;
    check("lat_n0", pass_cnt, 0);
    tick();
    check("lat_n1", pass_cnt, 0);
    tick();
    check("lat_n2", pass_cnt, 1);
    feed(16'h0001, 16'h0002, 16'd0, 0);
    in_valid = 0;
    pulse_start();
    check("start_run_busy", busy, 1);
    for (int i = 0; i < 4; i++) feed(va[i], vb[i], vo[i], 0);
    wait_done();
    check_stats("ign");

    // reset mid-run after 3 accepts
    pulse_start(); m_clear();
    feed(16'h0004, 16'h0002, 16'd1, 0);
    feed(16'h0002, 16'h0004, 16'd1, 0);
    feed(16'h0003, 16'h0003, 16'd0, 0);
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    check("mrst_busy", busy, 0);
    check("mrst_ready", in_ready, 0);
    check("mrst_pass", pass_cnt, 0);
    check("mrst_fail", fail_cnt, 0);
    check("mrst_ffv", ff_valid, 0);
    check("mrst_done", done, 0);
    pulse_start(); m_clear();
    for (int i = 0; i < 5; i++) feed(va[i], vb[i], vo[i], 0);
    in_valid = 0;
    tick(); tick(); tick(); tick();
    check("restart_busy", busy, 1);
    feed(va[5], vb[5], vo[5], 0);
    wait_done();
    check_stats("restart");

    // randomized runs with gaps and corrupted responses
    for (int r = 0; r < 10; r++) begin
      pulse_start(); m_clear();
      for (int i = 0; i < 6; i++) begin
        logic [15:0] a, b;
        logic [16:0] g;
        int gap;
        a = $urandom;
        b = $urandom;
        if ($urandom_range(0, 3) == 0) a = {~b[15], a[14:0]};
        g = ref_gold(a, b);
        if ($urandom_range(0, 3) == 0) g[$urandom_range(0, 16)] ^= 1'b1;
        gap = $urandom_range(0, 2);
        in_valid = 0;
        for (int k = 0; k < gap; k++) tick();
        feed(a, b, g[15:0], g[16]);
      end
      wait_done();
      check_stats("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
